// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives instr_mem from the pc, registers the fetched
// word toward decode with valid/ready flow control, branch redirect and halt handling.
module fetch_ctrl #(
    parameter int unsigned           PC_W     = 8,
    parameter int unsigned           INSTR_W  = 16,
    parameter logic [PC_W-1:0]       RESET_PC = '0,
    parameter logic [3:0]            HALT_OP  = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic               halted,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        stall_cnt
);

    typedef enum logic {
        S_RUN,
        S_HALT
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_nxt;
    logic               r_id_valid;
    logic               w_id_valid_nxt;
    logic [INSTR_W-1:0] r_id_instr;
    logic [INSTR_W-1:0] w_id_instr_nxt;
    logic [PC_W-1:0]    r_id_pc;
    logic [PC_W-1:0]    w_id_pc_nxt;
    logic [15:0]        r_fetch_cnt;
    logic [15:0]        r_stall_cnt;

    logic w_slot_free;
    logic w_is_halt;
    logic w_accept;
    logic w_stall;

    assign w_slot_free = ~r_id_valid | id_ready;
    assign w_is_halt   = (imem_data[INSTR_W-1 -: 4] == HALT_OP);
    assign w_accept    = r_id_valid & id_ready;
    assign w_stall     = r_id_valid & ~id_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
            r_id_pc    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_id_valid <= w_id_valid_nxt;
            r_id_instr <= w_id_instr_nxt;
            r_id_pc    <= w_id_pc_nxt;
        end
    end

    // Redirect wins over everything; the word fetched at the old pc is dropped.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_id_valid_nxt = r_id_valid;
        w_id_instr_nxt = r_id_instr;
        w_id_pc_nxt    = r_id_pc;
        if (redirect_valid) begin
            w_state_nxt    = S_RUN;
            w_pc_nxt       = redirect_pc;
            w_id_valid_nxt = 1'b0;
        end else begin
            unique case (r_state)
                S_RUN: begin
                    if (w_slot_free) begin
                        w_id_instr_nxt = imem_data;
                        w_id_pc_nxt    = r_pc;
                        w_id_valid_nxt = 1'b1;
                        if (w_is_halt) begin
                            w_state_nxt = S_HALT;
                        end else begin
                            w_pc_nxt = r_pc + PC_W'(1);
                        end
                    end
                end
                S_HALT: begin
                    if (id_ready) begin
                        w_id_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_accept && (r_fetch_cnt != '1)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign imem_addr = r_pc;
    assign id_valid  = r_id_valid;
    assign id_instr  = r_id_instr;
    assign id_pc     = r_id_pc;
    assign halted    = (r_state == S_HALT);
    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: behavioural fetch model compared every cycle, directed
// literal checks for the basic, stall, redirect, halt, wrap and async-reset cases.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [7:0]  id_pc;
    logic        halted;
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;

    // second instance starting near the top of the address space
    logic [7:0]  w_addr;
    logic [15:0] w_data;
    logic        w_valid;
    logic [15:0] w_instr;
    logic [7:0]  w_pc;
    logic        w_halted;
    logic [15:0] w_fcnt;
    logic [15:0] w_scnt;

    logic [15:0] mem [256];

    int total = 0;
    int bad   = 0;

    // model state
    logic [7:0]  m_pc;
    logic        m_halt;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [7:0]  m_idpc;
    logic [15:0] m_fcnt;
    logic [15:0] m_scnt;

    assign imem_data = mem[imem_addr];
    assign w_data    = {8'h20, w_addr};

    fetch_ctrl #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00), .HALT_OP(4'hF)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .halted(halted),
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
    );

    fetch_ctrl #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'hFE), .HALT_OP(4'hF)) u_wrap (
        .clk(clk), .rst(rst), .imem_addr(w_addr), .imem_data(w_data),
        .redirect_valid(1'b0), .redirect_pc(8'h00), .id_ready(1'b1),
        .id_valid(w_valid), .id_instr(w_instr), .id_pc(w_pc), .halted(w_halted),
        .fetch_cnt(w_fcnt), .stall_cnt(w_scnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: what decode should see, from the fetch rules directly.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc    <= 8'h00;
            m_halt  <= 1'b0;
            m_valid <= 1'b0;
            m_instr <= 16'h0;
            m_idpc  <= 8'h00;
            m_fcnt  <= 16'h0;
            m_scnt  <= 16'h0;
        end else begin
            if (m_valid && id_ready && m_fcnt != 16'hFFFF) m_fcnt <= m_fcnt + 16'd1;
            if (m_valid && !id_ready && m_scnt != 16'hFFFF) m_scnt <= m_scnt + 16'd1;
            if (redirect_valid) begin
                m_pc    <= redirect_pc;
                m_valid <= 1'b0;
                m_halt  <= 1'b0;
            end else if (m_halt) begin
                if (id_ready) m_valid <= 1'b0;
            end else if (!m_valid || id_ready) begin
                m_instr <= mem[m_pc];
                m_idpc  <= m_pc;
                m_valid <= 1'b1;
                if (mem[m_pc][15:12] == 4'hF) m_halt <= 1'b1;
                else m_pc <= m_pc + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        chk("imem_addr", imem_addr, m_pc);
        chk("id_valid", id_valid, m_valid);
        chk("id_instr", id_instr, m_instr);
        chk("id_pc", id_pc, m_idpc);
        chk("halted", halted, m_halt);
        chk("fetch_cnt", fetch_cnt, m_fcnt);
        chk("stall_cnt", stall_cnt, m_scnt);
    end

    initial begin
        logic [7:0] exp_w;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        id_ready       = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
        for (int i = 0; i < 5; i++) mem[i] = 16'h1001 + 16'(i);
        mem[8'h40] = 16'h2040;
        mem[8'h41] = 16'h2041;
        mem[8'h42] = 16'h2042;
        mem[8'h43] = 16'hF000;
        #1;
        chk("rst_valid", id_valid, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fcnt", fetch_cnt, 0);
        chk("rst_wrap_addr", w_addr, 8'hFE);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        id_ready = 1'b1;

        // sequential fetch 0..4 and wrap FE,FF,00,01
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("seq_pc", id_pc, i);
            chk("seq_instr", id_instr, 16'h1001 + 16'(i));
            exp_w = 8'hFE + 8'(i);
            if (i < 4) chk("wrap_pc", w_pc, exp_w);
        end
        @(negedge clk);
        chk("seq_fcnt", fetch_cnt, 5);

        // stall 3 cycles holding id_pc=5
        id_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_pc", id_pc, 5);
        chk("stall_addr", imem_addr, 6);
        chk("stall_cnt", stall_cnt, 3);
        id_ready = 1'b1;
        @(negedge clk);
        chk("resume_pc", id_pc, 6);

        // redirect while stalled flushes the slot
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        @(negedge clk);
        chk("redir_valid", id_valid, 0);
        chk("redir_addr", imem_addr, 8'h40);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        @(negedge clk);
        chk("redir_pc", id_pc, 8'h40);
        chk("redir_valid2", id_valid, 1);

        // halt word at 0x43
        repeat (3) @(negedge clk);
        chk("halt_pc", id_pc, 8'h43);
        chk("halt_instr", id_instr, 16'hF000);
        chk("halt_flag", halted, 1);
        chk("halt_addr", imem_addr, 8'h43);
        @(negedge clk);
        chk("halt_drain", id_valid, 0);
        repeat (2) @(negedge clk);
        chk("halt_idle", id_valid, 0);
        chk("halt_addr2", imem_addr, 8'h43);
        redirect_valid = 1'b1;
        redirect_pc    = 8'h00;
        @(negedge clk);
        chk("unhalt", halted, 0);
        chk("unhalt_addr", imem_addr, 0);
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("restart_pc", id_pc, 0);

        // randomized traffic with occasional halt words
        for (int i = 0; i < 256; i++) begin
            mem[i] = {($urandom_range(0, 99) < 4) ? 4'hF : 4'($urandom_range(0, 14)), 12'($urandom)};
        end
        for (int c = 0; c < 3000; c++) begin
            id_ready       = ($urandom_range(0, 99) < 70);
            redirect_valid = ($urandom_range(0, 99) < (m_halt ? 30 : 5));
            redirect_pc    = 8'($urandom);
            @(negedge clk);
        end

        // async reset in the middle of a stall at id_pc=5
        mem[5]         = 16'h1234;
        mem[0]         = 16'h1001;
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h05;
        @(negedge clk);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        @(negedge clk);
        chk("pre_rst_pc", id_pc, 5);
        id_ready = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", id_valid, 0);
        chk("arst_pc", id_pc, 0);
        chk("arst_addr", imem_addr, 0);
        chk("arst_fcnt", fetch_cnt, 0);
        chk("arst_scnt", stall_cnt, 0);
        @(negedge clk);
        rst      = 1'b0;
        id_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_pc", id_pc, 0);
        chk("post_rst_instr", id_instr, 16'h1001);
        chk("post_rst_fcnt", fetch_cnt, 0);
        @(negedge clk);
        chk("post_rst_fcnt2", fetch_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
